uart_rx_fifo: RTL and testbench

- Serial 8N1 UART receiver with a small first-word-fall-through (FWFT) receive FIFO.
- Completes the SoC's UART pair: takes the top-level RXD pin and feeds received bytes to the CPU's memory-mapped IO read path.
- It is the receive counterpart to corescore_emitter_uart on TXD.
- The SoC decode drives i_rd and i_clr_err; this block only exposes the byte/status outputs.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/rx_fifo_fwft.sv | 65 ++++++
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Packs the receiver status bits into the 32-bit word read by the SoC mux.
  function automatic logic [31:0] status_word(input logic frame_err,
                                              input logic overrun,
                                              input logic busy,
                                              input logic valid);
    return {28'b0, frame_err, overrun, busy, valid};
  endfunction

endpackage

// File: rtl/rx_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is always presented on rdata.
// Full/empty come from the level counter; pointers wrap at DEPTH (power of 2).
module rx_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(DEPTH));
  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when the head leaves in the same cycle.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && full && !pop_ok;

  assign valid = !empty;
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage write port.
  // NOTE: the data array has no reset; level gates every read, so stale
  // contents are never observable and the array can map to plain RAM/regs.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small FWFT FIFO, with sticky overrun and
// framing-error flags for the CPU status register.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int clk_freq_hz = 12000000,
  parameter int baud_rate   = 9600,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rxd,
  input  logic                          i_rd,
  input  logic                          i_clr_err,
  output logic [7:0]                    o_rdata,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overrun,
  output logic                          o_frame_err,
  output logic                          o_busy
);

  localparam int DIV   = clk_freq_hz / baud_rate;
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DATA_BITS);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 push;
  logic                 frame_set;
  logic                 overflow;

  // Two-flop synchroniser for the asynchronous RXD pin; idles high.
  // NOTE: clocked state always uses non-blocking assignment so every flop
  // samples the pre-edge value of its neighbours, giving a true 2-stage chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rxd;
      rx_s    <= rx_meta;
    end
  end

  assign tick      = (baud_cnt == '0);
  // The byte is pushed in the stop-bit tick cycle itself, so it appears at
  // the FIFO head on the following cycle.
  assign push      = (state == STOP) && tick && rx_s;
  assign frame_set = (state == STOP) && tick && !rx_s;
  assign o_busy    = (state != IDLE);

  // Receive FSM: start detect, half-bit alignment, 8 data bits, stop check.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            baud_cnt <= CNT_W'(DIV / 2 - 1);
            state    <= START;
          end
        end
        START: begin
          if (!tick) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else if (rx_s) begin
            // Line went high again by mid start bit: treat as a glitch.
            state <= IDLE;
          end else begin
            baud_cnt <= CNT_W'(DIV - 1);
            bit_idx  <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (!tick) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            // LSB arrives first, so shifting in at the MSB leaves bit 0 at
            // shreg[0] after the eighth sample.
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            baud_cnt <= CNT_W'(DIV - 1);
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (!tick) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            // Low stop bit: wait for the line to recover so a held break is
            // not decoded as a stream of 0x00 frames.
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle as a clear wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (overflow)       o_overrun <= 1'b1;
      else if (i_clr_err) o_overrun <= 1'b0;
      if (frame_set)      o_frame_err <= 1'b1;
      else if (i_clr_err) o_frame_err <= 1'b0;
    end
  end

  rx_fifo_fwft #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (push),
    .wdata    (shreg),
    .pop      (i_rd),
    .rdata    (o_rdata),
    .valid    (o_valid),
    .level    (o_level),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=16. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rd;
  logic       clr_err;
  logic [7:0] rdata;
  logic       valid;
  logic [3:0] level;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .clk_freq_hz (16),
    .baud_rate   (1),
    .FIFO_DEPTH  (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rxd       (rxd),
    .i_rd        (rd),
    .i_clr_err   (clr_err),
    .o_rdata     (rdata),
    .o_valid     (valid),
    .o_level     (level),
    .o_overrun   (overrun),
    .o_frame_err (frame_err),
    .o_busy      (busy)
  );

  // Start bit plus eight data bits, 16 clocks each (144 clocks).
  task automatic send_head(input logic [7:0] d);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (16) @(negedge clk);
    end
  endtask

  // Full frame. The stop-bit tick lands on the rising edge after falling
  // edge 154 of the frame; rd_at/clr_at are asserted for exactly that edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_val,
                            input logic rd_at, input logic clr_at);
    send_head(d);
    rxd = stop_val;
    repeat (10) @(negedge clk);
    rd      = rd_at;
    clr_err = clr_at;
    @(negedge clk);
    rd      = 1'b0;
    clr_err = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_one;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rxd = 1'b1; rd = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    send_head(8'hA5);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", valid); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", valid); end
    n_cmp++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL single_rdata got=%h exp=a5", rdata); end
    n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level got=%0d exp=1", level); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got=%b exp=0", busy); end
    repeat (5) @(negedge clk);
    pop_one();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got=%b exp=0", valid); end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL single_pop_rdata got=%h exp=00", rdata); end
    pop_one();
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL empty_pop_level got=%0d exp=0", level); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL empty_pop_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL b2b_level got=%0d exp=8", level); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
    for (int i = 1; i <= 8; i++) begin
      n_cmp++; if (rdata !== 8'(i)) begin n_fail++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, rdata, 8'(i)); end
      pop_one();
    end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_valid got=%b exp=0", valid); end
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL b2b_empty_level got=%0d exp=0", level); end
    pulse_clr();
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_clr_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_low got=%b exp=1", busy); end
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL ferr_level got=%0d exp=0", level); end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_high got=%b exp=0", busy); end
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 8'h55) begin n_fail++; $display("FAIL ferr_next_rdata got=%h exp=55", rdata); end
    n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL ferr_next_level got=%0d exp=1", level); end
    pop_one();
    pulse_clr();
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clr got=%b exp=0", frame_err); end
  endtask

  task automatic test_glitch;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL glitch_level got=%0d exp=0", level); end
    n_cmp++; if ({overrun, frame_err} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags got=%b exp=00", {overrun, frame_err}); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_q [8];
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
    n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_level got=%0d exp=8", level); end
    send_frame(8'h77, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL pushpop_level got=%0d exp=8", level); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL pushpop_overrun got=%b exp=0", overrun); end
    n_cmp++; if (rdata !== 8'h11) begin n_fail++; $display("FAIL pushpop_head got=%h exp=11", rdata); end
    send_frame(8'h88, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL set_wins_overrun got=%b exp=1", overrun); end
    for (int i = 0; i < 7; i++) exp_q[i] = 8'h11 + 8'(i);
    exp_q[7] = 8'h77;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rdata !== exp_q[i]) begin n_fail++; $display("FAIL full_pop%0d got=%h exp=%h", i, rdata, exp_q[i]); end
      pop_one();
    end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_valid got=%b exp=0", valid); end
    pulse_clr();
  endtask

  task automatic test_reset_mid;
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL mid_rst_level got=%0d exp=0", level); end
    n_cmp++; if ({overrun, frame_err, valid} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_flags got=%b exp=000", {overrun, frame_err, valid}); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (rdata !== 8'hC3) begin n_fail++; $display("FAIL mid_next_rdata got=%h exp=c3", rdata); end
    n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL mid_next_level got=%0d exp=1", level); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_next_frame_err got=%b exp=0", frame_err); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_full_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
